// File: rtl/align_p2s_arb.sv
// ---------------------------------------------------------------------------
// align_p2s_arb
//
// Round-robin scheduler in front of a shared wide-to-narrow serializer.
// REQ_NUM requesters each offer one IDATA_BIT word with a valid/ready
// handshake. One word is granted at a time, captured into a local buffer and
// streamed out as REG_NUM beats of ODATA_BIT bits, least-significant segment
// first. Every beat carries the id of its source and a last-beat flag.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_data     requester words, requester i at [i*IDATA_BIT +: IDATA_BIT]
//   req_valid    per-requester word valid
//   req_ready    per-requester accept (one-hot or zero, only while idle)
//   odata        current output beat
//   odata_valid  output beat valid
//   odata_ready  downstream accepts the current beat
//   odata_src    requester index of the word being streamed
//   odata_last   high on the final beat of a word
//   busy         high while a word is being streamed
// ---------------------------------------------------------------------------
module align_p2s_arb #(
    parameter int REQ_NUM   = 4,
    parameter int IDATA_BIT = 256,
    parameter int ODATA_BIT = 64,
    parameter int SRC_BIT   = $clog2(REQ_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REQ_NUM*IDATA_BIT-1:0] req_data,
    input  logic [REQ_NUM-1:0]           req_valid,
    output logic [REQ_NUM-1:0]           req_ready,
    output logic [ODATA_BIT-1:0]         odata,
    output logic                         odata_valid,
    input  logic                         odata_ready,
    output logic [SRC_BIT-1:0]           odata_src,
    output logic                         odata_last,
    output logic                         busy
);

    localparam int REG_NUM = IDATA_BIT / ODATA_BIT;
    localparam int CNT_BIT = $clog2(REG_NUM);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_BIT-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_BIT-1:0]   src_q, src_d;
    logic [CNT_BIT-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDATA_BIT-1:0] buf_q, buf_d;

    logic [SRC_BIT-1:0]   grant;
    logic                 grant_found;
    logic                 handshake;
    logic                 last_beat;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // Re-evaluated every cycle, so nothing is committed before the handshake.
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a signal unassigned would infer a latch.
    always_comb begin
        logic [SRC_BIT-1:0] idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            // Explicit modulo keeps the wrap correct for non-power-of-two REQ_NUM.
            idx = SRC_BIT'((int'(rr_ptr_q) + i) % REQ_NUM);
            if (!grant_found && req_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    // Ready is offered only in IDLE and is gated by rst_n so it drops
    // immediately when reset is asserted, independent of the clock.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign last_beat = (beat_cnt_q == CNT_BIT'(REG_NUM - 1));

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        src_d      = src_q;
        beat_cnt_d = beat_cnt_q;
        buf_d      = buf_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    for (int r = 0; r < REQ_NUM; r++) begin
                        if (grant == SRC_BIT'(r)) begin
                            buf_d = req_data[r*IDATA_BIT +: IDATA_BIT];
                        end
                    end
                    src_d      = grant;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (grant == SRC_BIT'(REQ_NUM - 1)) ? '0
                                                                  : grant + SRC_BIT'(1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (odata_ready) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_BIT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            src_q      <= '0;
            beat_cnt_q <= '0;
            // NOTE: the word buffer is reset (not left uninitialised) because
            // its segment 0 is visible on odata while idle.
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            src_q      <= src_d;
            beat_cnt_q <= beat_cnt_d;
            buf_q      <= buf_d;
        end
    end

    // Output segment select; beat_cnt is 0 while idle, so segment 0 shows.
    always_comb begin
        odata = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            if (beat_cnt_q == CNT_BIT'(k)) begin
                odata = buf_q[k*ODATA_BIT +: ODATA_BIT];
            end
        end
    end

    assign odata_valid = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign odata_src   = src_q;
    assign odata_last  = (state_q == SEND) && last_beat;

endmodule
